apb2axi_wr_arbiter: RTL

//  Shares one AXI3 write port (AW/W/B) among N_REQ write builders. Arbitrates AW round-robin
//  and records grant order in an order FIFO. Steers W beats strictly in AW-grant order.

---
 rtl/apb2axi_pkg.sv | 17 +
 rtl/apb2axi_wr_order_fifo.sv | 62 ++++++
 rtl/apb2axi_wr_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/apb2axi_pkg.sv
// Shared AXI constants for the APB-to-AXI bridge.
// Default bus widths and fixed AXI3 field encodings.
package apb2axi_pkg;

  localparam int DEF_AXI_ADDR_W = 32;
  localparam int DEF_AXI_DATA_W = 32;
  localparam int DEF_AXI_ID_W   = 4;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/apb2axi_wr_order_fifo.sv
// Small synchronous FIFO holding AW grant order.
// Push and pop may coincide even when full.
module apb2axi_wr_order_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_din,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_dout,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  // Pointers and occupancy.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  // Storage, no reset needed.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/apb2axi_wr_arbiter.sv
// Shares one AXI3 write port among N_REQ builders.
// Round-robin AW, W in grant order, B routed by ID.
module apb2axi_wr_arbiter
  import apb2axi_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int AXI_ADDR_W  = DEF_AXI_ADDR_W,
  parameter int AXI_DATA_W  = DEF_AXI_DATA_W,
  parameter int AXI_ID_W    = DEF_AXI_ID_W,
  parameter int ORDER_DEPTH = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_REQ-1:0]             s_awvalid,
  output logic [N_REQ-1:0]             s_awready,
  input  logic [N_REQ*AXI_ID_W-1:0]    s_awid,
  input  logic [N_REQ*AXI_ADDR_W-1:0]  s_awaddr,
  input  logic [N_REQ*4-1:0]           s_awlen,
  input  logic [N_REQ*3-1:0]           s_awsize,
  input  logic [N_REQ-1:0]             s_wvalid,
  output logic [N_REQ-1:0]             s_wready,
  input  logic [N_REQ*AXI_DATA_W-1:0]  s_wdata,
  input  logic [N_REQ*AXI_DATA_W/8-1:0] s_wstrb,
  input  logic [N_REQ-1:0]             s_wlast,
  output logic [N_REQ-1:0]             s_bvalid,
  input  logic [N_REQ-1:0]             s_bready,
  output logic [1:0]                   s_bresp,
  output logic [AXI_ID_W-1:0]          m_awid,
  output logic [AXI_ADDR_W-1:0]        m_awaddr,
  output logic [3:0]                   m_awlen,
  output logic [2:0]                   m_awsize,
  output logic [1:0]                   m_awburst,
  output logic [1:0]                   m_awlock,
  output logic [3:0]                   m_awcache,
  output logic [2:0]                   m_awprot,
  output logic                         m_awvalid,
  input  logic                         m_awready,
  output logic [AXI_DATA_W-1:0]        m_wdata,
  output logic [AXI_DATA_W/8-1:0]      m_wstrb,
  output logic                         m_wlast,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  input  logic [AXI_ID_W-1:0]          m_bid,
  input  logic [1:0]                   m_bresp,
  input  logic                         m_bvalid,
  output logic                         m_bready,
  output logic [$clog2(ORDER_DEPTH+1)-1:0] wr_outstanding,
  output logic                         err_bid
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int STRB_W = AXI_DATA_W / 8;

  typedef enum logic {
    ST_IDLE,
    ST_AW_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] w_grant_nxt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_rr_nxt;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_wact;
  logic [IDX_W-1:0] w_head;
  logic [IDX_W-1:0] w_bidx;

  // Round-robin search from rr_ptr, wrapping.
  always_comb begin
    w_pick  = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && s_awvalid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // AW state, grant and rr pointer.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // AW next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_push      = 1'b0;
    m_awvalid   = 1'b0;
    s_awready   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found && !w_full) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ST_AW_HOLD;
        end
      end
      ST_AW_HOLD: begin
        m_awvalid = aresetn;
        if (m_awready && aresetn) begin
          s_awready[r_grant] = 1'b1;
          w_push      = 1'b1;
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = (r_grant == IDX_W'(N_REQ - 1))
                      ? '0 : r_grant + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // AW payload from the granted requester.
  always_comb begin
    m_awid    = s_awid[r_grant*AXI_ID_W +: AXI_ID_W];
    m_awid[IDX_W-1:0] = r_grant;
    m_awaddr  = s_awaddr[r_grant*AXI_ADDR_W +: AXI_ADDR_W];
    m_awlen   = s_awlen[r_grant*4 +: 4];
    m_awsize  = s_awsize[r_grant*3 +: 3];
    m_awburst = AXI_BURST_INCR;
    m_awlock  = 2'b00;
    m_awcache = AXI_CACHE_DEFAULT;
    m_awprot  = 3'b000;
  end

  apb2axi_wr_order_fifo #(
    .W     (IDX_W),
    .DEPTH (ORDER_DEPTH)
  ) u_order (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_push  (w_push),
    .i_din   (r_grant),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (wr_outstanding)
  );

  assign w_wact = !w_empty && aresetn;
  assign w_pop  = m_wvalid && m_wready && m_wlast;

  // W steering from the oldest granted requester.
  always_comb begin
    m_wdata  = s_wdata[w_head*AXI_DATA_W +: AXI_DATA_W];
    m_wstrb  = s_wstrb[w_head*STRB_W +: STRB_W];
    m_wlast  = s_wlast[w_head];
    m_wvalid = w_wact && s_wvalid[w_head];
    s_wready = '0;
    if (w_wact) s_wready[w_head] = m_wready;
  end

  assign w_bidx  = m_bid[IDX_W-1:0];
  assign s_bresp = m_bresp;

  // B routing by ID index; unmapped ones are drained.
  always_comb begin
    s_bvalid = '0;
    m_bready = 1'b1;
    err_bid  = 1'b0;
    if ({1'b0, w_bidx} < (IDX_W+1)'(N_REQ)) begin
      s_bvalid[w_bidx] = m_bvalid;
      m_bready = s_bready[w_bidx];
    end else begin
      err_bid = m_bvalid;
    end
  end

endmodule
